// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the memory stage: MemOp encodings, field widths,
// pipeline-register layouts and access-size decode helpers.
package mem_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned MEMOP_BITS = 3;

  localparam logic [MEMOP_BITS-1:0] MEMOP_W  = 3'd0;
  localparam logic [MEMOP_BITS-1:0] MEMOP_H  = 3'd1;
  localparam logic [MEMOP_BITS-1:0] MEMOP_HU = 3'd2;
  localparam logic [MEMOP_BITS-1:0] MEMOP_B  = 3'd3;
  localparam logic [MEMOP_BITS-1:0] MEMOP_BU = 3'd4;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } acc_size_e;

  typedef struct packed {
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       write_data;
    logic [REG_AW-1:0]     rd;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic [MEMOP_BITS-1:0] mem_op;
  } exmem_t;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } memwb_t;

  // Unused encodings 5-7 fall into the word case.
  function automatic acc_size_e memop_size(input logic [MEMOP_BITS-1:0] op);
    case (op)
      MEMOP_H, MEMOP_HU: memop_size = SZ_HALF;
      MEMOP_B, MEMOP_BU: memop_size = SZ_BYTE;
      default:           memop_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic memop_signed(input logic [MEMOP_BITS-1:0] op);
    memop_signed = (op == MEMOP_H) || (op == MEMOP_B);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX-side inputs and MEM/WB-side outputs of the memory stage, bundled as one
// interface; signal names match the legacy port names.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [XLEN-1:0]       ALUResult_ex;
  logic [XLEN-1:0]       MemWriteData_ex;
  logic [REG_AW-1:0]     RegWriteAddr_ex;
  logic                  RegWrite_ex;
  logic                  MemtoReg_ex;
  logic                  MemWrite_ex;
  logic [MEMOP_BITS-1:0] MemOp_ex;

  logic [XLEN-1:0]       ALUResult_mem;
  logic [REG_AW-1:0]     RegWriteAddr_mem;
  logic                  RegWrite_mem;

  logic [XLEN-1:0]       RegWriteData_wb;
  logic [REG_AW-1:0]     RegWriteAddr_wb;
  logic                  RegWrite_wb;

  logic                  AlignErr;

  modport master (
    output ALUResult_ex, MemWriteData_ex, RegWriteAddr_ex, RegWrite_ex,
           MemtoReg_ex, MemWrite_ex, MemOp_ex,
    input  ALUResult_mem, RegWriteAddr_mem, RegWrite_mem,
           RegWriteData_wb, RegWriteAddr_wb, RegWrite_wb, AlignErr
  );

  modport slave (
    input  ALUResult_ex, MemWriteData_ex, RegWriteAddr_ex, RegWrite_ex,
           MemtoReg_ex, MemWrite_ex, MemOp_ex,
    output ALUResult_mem, RegWriteAddr_mem, RegWrite_mem,
           RegWriteData_wb, RegWriteAddr_wb, RegWrite_wb, AlignErr
  );
endinterface

// File: rtl/mem_stage_dmem_bytelane.sv
// Word-organised data RAM with per-byte-lane write enables.
// Reads are combinational; writes commit on the rising clock edge.
module dmem_bytelane
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  acc_size_e       size,
  input  logic [1:0]      offset,
  input  logic [AW-1:0]   index,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [3:0]      lane_en;
  logic [XLEN-1:0] lane_data;

  // Replicate the narrow store data across all lanes; the enables pick the target.
  always_comb begin
    lane_en   = '0;
    lane_data = '0;
    case (size)
      SZ_HALF: begin
        lane_en   = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        lane_en   = 4'b0001 << offset;
        lane_data = {4{wdata[7:0]}};
      end
      default: begin
        lane_en   = '1;
        lane_data = wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[index][i*8 +: 8] <= lane_data[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, data RAM access, load extraction and
// MEM/WB register. Define MEM_ALIGN_CHECK_EN to trap misaligned W/H accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_stage_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  exmem_t          exmem_d, exmem_q;
  memwb_t          memwb_d, memwb_q;
  logic            align_err_d, align_err_q;

  acc_size_e       size;
  logic [1:0]      raw_off;
  logic [1:0]      off;
  logic            misaligned;
  logic            ram_we;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] byte_shift;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  always_comb begin
    exmem_d = '{
      alu_result: bus.ALUResult_ex,
      write_data: bus.MemWriteData_ex,
      rd:         bus.RegWriteAddr_ex,
      reg_write:  bus.RegWrite_ex,
      mem_to_reg: bus.MemtoReg_ex,
      mem_write:  bus.MemWrite_ex,
      mem_op:     bus.MemOp_ex
    };
  end

  assign size    = memop_size(exmem_q.mem_op);
  assign raw_off = exmem_q.alu_result[1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((size == SZ_WORD) && (raw_off != 2'b00)) ||
                      ((size == SZ_HALF) && raw_off[0]);
  assign off        = raw_off;
`else
  // Unchecked build silently rounds the offset down to the natural boundary.
  assign misaligned = 1'b0;
  always_comb begin
    off = raw_off;
    case (size)
      SZ_WORD: off = 2'b00;
      SZ_HALF: off = {raw_off[1], 1'b0};
      default: off = raw_off;
    endcase
  end
`endif

  assign ram_we = exmem_q.mem_write && !misaligned;

  dmem_bytelane #(
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk    (clk),
    .we     (ram_we),
    .size   (size),
    .offset (off),
    .index  (exmem_q.alu_result[AW+1:2]),
    .wdata  (exmem_q.write_data),
    .rdata  (rdata)
  );

  assign byte_shift = rdata >> {off, 3'b000};
  assign half_sel   = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (size)
      SZ_HALF: load_data = memop_signed(exmem_q.mem_op) ? {{16{half_sel[15]}}, half_sel}
                                                        : {16'h0000, half_sel};
      SZ_BYTE: load_data = memop_signed(exmem_q.mem_op) ? {{24{byte_shift[7]}}, byte_shift[7:0]}
                                                        : {24'h000000, byte_shift[7:0]};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    memwb_d = '{
      result:    exmem_q.mem_to_reg ? load_data : exmem_q.alu_result,
      rd:        exmem_q.rd,
      reg_write: exmem_q.reg_write && !(exmem_q.mem_to_reg && misaligned)
    };
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err_d = align_err_q ||
                       (misaligned && (exmem_q.mem_write || exmem_q.mem_to_reg));
`else
  assign align_err_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_q     <= '0;
      memwb_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.ALUResult_mem    = exmem_q.alu_result;
  assign bus.RegWriteAddr_mem = exmem_q.rd;
  assign bus.RegWrite_mem     = exmem_q.reg_write;
  assign bus.RegWriteData_wb  = memwb_q.result;
  assign bus.RegWriteAddr_wb  = memwb_q.rd;
  assign bus.RegWrite_wb      = memwb_q.reg_write;
  assign bus.AlignErr         = align_err_q;

endmodule
